fetch_unit: RTL and testbench

Instruction-fetch stage of the five-stage core: owns the program counter, drives the instruction-bus request/response handshake and produces the `fetch_data_t` record consumed by decode. It sits directly upstream of decode and takes a redirect (taken branch/JAL/JALR target) from execute and a stall from the hazard logic. Throughput is one instruction per cycle when the bus answers with zero wait states.

---
 rtl/fetch_unit.sv | 132 +++++++++++++
 tb/tb_fetch_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, I-bus handshake, F/D slot.
// One request in flight; parks one word when decode stalls.
package fetch_pkg;
  typedef struct packed {
    logic [31:0] raw_instr;
    logic [63:0] pc;
    logic        valid;
  } fetch_data_t;
endpackage

module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output fetch_data_t dataF
);

  typedef enum logic [1:0] {
    S_REQ,
    S_HOLD,
    S_KILL
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] kill_q, kill_d;
  fetch_data_t slot_q, slot_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [63:0] hold_pc_q, hold_pc_d;
  logic        ireq_valid_q, ireq_valid_d;
  logic [63:0] ireq_addr_q, ireq_addr_d;

  logic drain;
  logic room;

  assign drain = slot_q.valid & ~stall;
  assign room  = ~slot_q.valid | drain;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    kill_d       = kill_q;
    slot_d       = slot_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    if (drain) slot_d.valid = 1'b0;
    unique case (state_q)
      S_REQ: begin
        if (iresp_data_ok) begin
          pc_d = pc_q + 64'd4;
          if (room) begin
            slot_d = '{raw_instr: iresp_data,
                       pc: pc_q, valid: 1'b1};
          end else begin
            hold_instr_d = iresp_data;
            hold_pc_d    = pc_q;
            state_d      = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (drain) begin
          slot_d = '{raw_instr: hold_instr_q,
                     pc: hold_pc_q, valid: 1'b1};
          state_d = S_REQ;
        end
      end
      S_KILL: begin
        if (iresp_data_ok) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
    // Redirect wins; an unanswered request must still be retired in KILL.
    if (redirect_valid) begin
      pc_d         = redirect_pc & ~64'h3;
      slot_d       = slot_q;
      slot_d.valid = 1'b0;
      unique case (state_q)
        S_REQ: begin
          if (iresp_data_ok) begin
            state_d = S_REQ;
          end else begin
            kill_d  = pc_q;
            state_d = S_KILL;
          end
        end
        S_HOLD:  state_d = S_REQ;
        S_KILL:  state_d = iresp_data_ok ? S_REQ : S_KILL;
        default: state_d = S_REQ;
      endcase
    end
    ireq_valid_d = (state_d != S_HOLD);
    ireq_addr_d  = (state_d == S_KILL) ? kill_d : pc_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      kill_q       <= '0;
      slot_q       <= '0;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
      ireq_valid_q <= 1'b0;
      ireq_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      kill_q       <= kill_d;
      slot_q       <= slot_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      ireq_valid_q <= ireq_valid_d;
      ireq_addr_q  <= ireq_addr_d;
    end
  end

  assign ireq_valid = ireq_valid_q;
  assign ireq_addr  = ireq_addr_q;
  assign dataF      = slot_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue scoreboard of fetched words,
// bus model answering from an address-derived memory.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [63:0] RESET_PC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        stall;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  fetch_data_t dataF;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] exp_pc;
  logic [63:0] kill_addr;
  bit          kill_pend;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .reset         (reset),
    .ireq_valid    (ireq_valid),
    .ireq_addr     (ireq_addr),
    .iresp_data_ok (iresp_data_ok),
    .iresp_data    (iresp_data),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .dataF         (dataF)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [63:0] got,
                       logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem(logic [63:0] a);
    return (a[31:0] - 32'h8000_0000) ^ 32'h0000_0013;
  endfunction

  task automatic model_reset();
    sb.delete();
    exp_pc    = RESET_PC;
    kill_pend = 1'b0;
    kill_addr = '0;
  endtask

  // Asserts reset mid-cycle, checks the async clear, releases.
  task automatic do_reset();
    #2;
    reset          = 1'b0;
    iresp_data_ok  = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    #1;
    check("rst_dataF_valid", dataF.valid, 0);
    check("rst_dataF_pc", dataF.pc, 0);
    check("rst_dataF_instr", dataF.raw_instr, 0);
    check("rst_ireq_valid", ireq_valid, 0);
    check("rst_ireq_addr", ireq_addr, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    model_reset();
  endtask

  task automatic step(bit want_ok, bit st, bit rd = 1'b0,
                      logic [63:0] rpc = '0);
    bit          exp_rv;
    logic [63:0] exp_addr;
    exp_rv   = kill_pend || (sb.size() < 2);
    exp_addr = kill_pend ? kill_addr : exp_pc;
    check("ireq_valid", ireq_valid, exp_rv);
    if (exp_rv) check("ireq_addr", ireq_addr, exp_addr);
    check("dataF_valid", dataF.valid, sb.size() > 0);
    if (sb.size() > 0) begin
      check("dataF_pc", dataF.pc, sb[0].pc);
      check("dataF_instr", dataF.raw_instr, sb[0].instr);
    end
    iresp_data_ok  = want_ok && exp_rv;
    iresp_data     = iresp_data_ok ? mem(exp_addr) : 32'hDEAD_BEEF;
    stall          = st;
    redirect_valid = rd;
    redirect_pc    = rpc;
    if (sb.size() > 0 && !st) void'(sb.pop_front());
    if (rd) begin
      if (iresp_data_ok) begin
        kill_pend = 1'b0;
      end else if (exp_rv && !kill_pend) begin
        kill_pend = 1'b1;
        kill_addr = exp_pc;
      end
      sb.delete();
      exp_pc = rpc & ~64'h3;
    end else if (iresp_data_ok) begin
      if (kill_pend) begin
        kill_pend = 1'b0;
      end else begin
        sb.push_back('{pc: exp_pc, instr: mem(exp_pc)});
        exp_pc = exp_pc + 64'd4;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    reset          = 1'b0;
    iresp_data_ok  = 1'b0;
    iresp_data     = '0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Zero-wait streaming
    repeat (4) step(1, 0);

    // Stall with a parked word
    do_reset();
    step(1, 0);
    repeat (3) step(1, 1);
    repeat (3) step(1, 0);

    // Redirect with a request outstanding
    do_reset();
    repeat (4) step(1, 0);
    step(0, 0, 1, 64'h8000_0100);
    step(0, 0);
    repeat (4) step(1, 0);

    // Redirect coincident with a response
    step(1, 0, 1, 64'h8000_0203);
    repeat (2) step(1, 0);

    // Redirect under stall, from HOLD and from REQ
    step(1, 1);
    step(1, 1, 1, 64'h8000_0300);
    repeat (2) step(1, 0);
    step(1, 1, 1, 64'h8000_0400);
    repeat (2) step(1, 0);

    // Redirect during KILL, then PC wrap
    step(0, 0, 1, 64'h8000_0500);
    step(0, 0, 1, 64'h8000_0600);
    step(1, 0, 1, 64'hFFFF_FFFF_FFFF_FFF8);
    repeat (5) step(1, 0);

    // Reset during a wait state
    repeat (2) step(0, 0);
    do_reset();
    repeat (2) step(1, 0);

    repeat (400) begin
      step($urandom_range(0, 3) != 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 15) == 0,
           RESET_PC + 64'($urandom_range(0, 4095)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
